// File: rtl/hex_ascii_streamer.sv
// hex_ascii_streamer
// Captures one WIDTH-bit word and streams its hex text one ASCII character per
// valid/ready handshake, most significant nibble first. An optional "0x"
// prefix, an optional CR/LF suffix and the letter case are fixed by parameters.
// All outputs come straight from flops. Each one is loaded from the value the
// FSM will hold after the edge, so a stalled character never changes.
module hex_ascii_streamer #(
  parameter int WIDTH      = 32,
  parameter int PREFIX_EN  = 0,
  parameter int NEWLINE_EN = 1,
  parameter int UPPERCASE  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_char,
  output logic             out_last,
  output logic             busy
);

  localparam int NDIG = WIDTH / 4;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(NDIG - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PFX0 = 3'd1,
    S_PFX1 = 3'd2,
    S_DIG  = 3'd3,
    S_CR   = 3'd4,
    S_LF   = 3'd5
  } state_t;

  // Map one nibble to its ASCII hex digit in the configured case.
  function automatic logic [7:0] nib_to_ascii(input logic [3:0] nib);
    logic [7:0] base;
    if (nib < 4'd10) begin
      base = 8'h30;
      return base + {4'h0, nib};
    end else begin
      base = (UPPERCASE != 0) ? 8'h41 : 8'h61;
      return base + {4'h0, nib} - 8'd10;
    end
  endfunction

  // Select nibble number cnt of the word (nibble 0 = least significant).
  function automatic logic [3:0] sel_nibble(input logic [WIDTH-1:0] word,
                                            input logic [CW-1:0]    cnt);
    logic [3:0] nib;
    nib = 4'h0;
    for (int i = 0; i < NDIG; i++) begin
      if (cnt == CW'(i)) begin
        nib = word[4*i +: 4];
      end else begin
        nib = nib;
      end
    end
    return nib;
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_word;
  logic [CW-1:0]    r_cnt;
  logic             r_out_valid;
  logic [7:0]       r_out_char;
  logic             r_out_last;
  logic             r_in_ready;
  logic             r_busy;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_word_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_out_valid_nxt;
  logic [7:0]       w_out_char_nxt;
  logic             w_out_last_nxt;
  logic             w_accept_in;
  logic             w_accept_out;

  assign w_accept_in  = in_valid && r_in_ready;
  assign w_accept_out = r_out_valid && out_ready;

  // State register: FSM state, captured word and digit counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_word  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_word  <= w_word_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic. An emit state advances only when its character is accepted.
  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept_in) begin
          w_word_nxt  = in_data;
          w_cnt_nxt   = CNT_TOP;
          w_state_nxt = (PREFIX_EN != 0) ? S_PFX0 : S_DIG;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PFX0: begin
        if (w_accept_out) w_state_nxt = S_PFX1;
        else              w_state_nxt = S_PFX0;
      end
      S_PFX1: begin
        if (w_accept_out) w_state_nxt = S_DIG;
        else              w_state_nxt = S_PFX1;
      end
      S_DIG: begin
        if (w_accept_out && (r_cnt == {CW{1'b0}})) begin
          w_state_nxt = (NEWLINE_EN != 0) ? S_CR : S_IDLE;
        end else if (w_accept_out) begin
          w_cnt_nxt = r_cnt - {{(CW-1){1'b0}}, 1'b1};
        end else begin
          w_state_nxt = S_DIG;
        end
      end
      S_CR: begin
        if (w_accept_out) w_state_nxt = S_LF;
        else              w_state_nxt = S_CR;
      end
      S_LF: begin
        if (w_accept_out) w_state_nxt = S_IDLE;
        else              w_state_nxt = S_LF;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode. It works from the next state, so the output flops already
  // hold the character belonging to the state being entered.
  always_comb begin
    w_out_valid_nxt = (w_state_nxt != S_IDLE);
    w_out_char_nxt  = 8'h00;
    w_out_last_nxt  = 1'b0;
    case (w_state_nxt)
      S_IDLE: begin
        w_out_char_nxt = 8'h00;
      end
      S_PFX0: begin
        w_out_char_nxt = 8'h30;
      end
      S_PFX1: begin
        w_out_char_nxt = 8'h78;
      end
      S_DIG: begin
        w_out_char_nxt = nib_to_ascii(sel_nibble(w_word_nxt, w_cnt_nxt));
        if ((NEWLINE_EN == 0) && (w_cnt_nxt == {CW{1'b0}})) w_out_last_nxt = 1'b1;
        else                                                 w_out_last_nxt = 1'b0;
      end
      S_CR: begin
        w_out_char_nxt = 8'h0D;
      end
      S_LF: begin
        w_out_char_nxt = 8'h0A;
        w_out_last_nxt = 1'b1;
      end
      default: begin
        w_out_char_nxt = 8'h00;
      end
    endcase
  end

  // Output registers for the stream and the handshake status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_char  <= 8'h00;
      r_out_last  <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_out_valid <= w_out_valid_nxt;
      r_out_char  <= w_out_char_nxt;
      r_out_last  <= w_out_last_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign out_valid = r_out_valid;
  assign out_char  = r_out_char;
  assign out_last  = r_out_last;
  assign in_ready  = r_in_ready;
  assign busy      = r_busy;

endmodule

// File: tb/tb_hex_ascii_streamer.sv
// Bench for hex_ascii_streamer. It runs three instances with different
// parameter sets and checks each one against a text-level model of the output.
module tb_hex_ascii_streamer;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid  [3];
  logic        out_ready [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic [7:0]  out_char  [3];
  logic        out_last  [3];
  logic        busy      [3];

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: defaults (32-bit, no prefix, CR/LF, upper case).
  hex_ascii_streamer #(.WIDTH(32), .PREFIX_EN(0), .NEWLINE_EN(1), .UPPERCASE(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[31:0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_char(out_char[0]), .out_last(out_last[0]), .busy(busy[0]));

  // Instance 1: 8-bit, "0x" prefix, CR/LF, lower case.
  hex_ascii_streamer #(.WIDTH(8), .PREFIX_EN(1), .NEWLINE_EN(1), .UPPERCASE(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[7:0]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_char(out_char[1]), .out_last(out_last[1]), .busy(busy[1]));

  // Instance 2: 4-bit, no prefix, no newline.
  hex_ascii_streamer #(.WIDTH(4), .PREFIX_EN(0), .NEWLINE_EN(0), .UPPERCASE(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[3:0]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_char(out_char[2]), .out_last(out_last[2]), .busy(busy[2]));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: the expected text written out as a character list.
  task automatic build_exp(input logic [31:0] w, input int width, input bit pfx,
                           input bit nl, input bit up);
    string hexu = "0123456789ABCDEF";
    string hexl = "0123456789abcdef";
    int d;
    exp_q.delete();
    if (pfx) begin
      exp_q.push_back(8'h30);
      exp_q.push_back(8'h78);
    end
    for (int k = width / 4 - 1; k >= 0; k--) begin
      d = int'((w >> (4 * k)) % 32'd16);
      exp_q.push_back(up ? hexu[d] : hexl[d]);
    end
    if (nl) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic check_idle(input int id, input string tag);
    check_val({tag, "_ov"},   32'(out_valid[id]), 32'd0);
    check_val({tag, "_ir"},   32'(in_ready[id]),  32'd1);
    check_val({tag, "_busy"}, 32'(busy[id]),      32'd0);
    check_val({tag, "_last"}, 32'(out_last[id]),  32'd0);
  endtask

  // Send one word to instance id and consume its characters. pulse_at injects
  // a second in_valid during the stream; abort_after stops after that many chars.
  task automatic run_word(input int id, input logic [31:0] w, input bit rnd_bp,
                          input int pulse_at, input int abort_after);
    int width;
    bit pfx, nl, up;
    int n, idx, cyc;
    logic [7:0] held_c;
    logic held_l;
    bit stalled;
    case (id)
      0: begin width = 32; pfx = 1'b0; nl = 1'b1; up = 1'b1; end
      1: begin width = 8;  pfx = 1'b1; nl = 1'b1; up = 1'b0; end
      default: begin width = 4; pfx = 1'b0; nl = 1'b0; up = 1'b1; end
    endcase
    build_exp(w, width, pfx, nl, up);
    n = exp_q.size();
    @(negedge clk);
    check_val("ready_before", 32'(in_ready[id]), 32'd1);
    in_data      = w;
    in_valid[id] = 1'b1;
    out_ready[id] = rnd_bp ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    in_valid[id] = 1'b0;
    in_data = $urandom;
    idx = 0; cyc = 0; stalled = 1'b0; held_c = 8'h00; held_l = 1'b0;
    while (idx < n && cyc < 2000 && !(abort_after > 0 && idx == abort_after)) begin
      cyc++;
      check_val("ov_stream", 32'(out_valid[id]), 32'd1);
      check_val("busy_stream", 32'(busy[id]), 32'd1);
      check_val("ir_stream", 32'(in_ready[id]), 32'd0);
      if (stalled) begin
        check_val("hold_char", 32'(out_char[id]), 32'(held_c));
        check_val("hold_last", 32'(out_last[id]), 32'(held_l));
      end
      in_valid[id] = (pulse_at == cyc);
      if (pulse_at == cyc) in_data = 32'h12345678;
      out_ready[id] = rnd_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_ready[id]) begin
        check_val("char", 32'(out_char[id]), 32'(exp_q[idx]));
        check_val("last", 32'(out_last[id]), 32'(idx == n - 1));
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held_c = out_char[id];
        held_l = out_last[id];
      end
      @(negedge clk);
    end
    in_valid[id]  = 1'b0;
    out_ready[id] = 1'b0;
    if (abort_after == 0) begin
      check_val("chars_done", 32'(idx), 32'(n));
      if (!rnd_bp) check_val("cycles", 32'(cyc), 32'(n));
      check_idle(id, "after");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_data = 32'h0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_idle(i, "rst");
      check_val("rst_char", 32'(out_char[i]), 32'h0);
    end
    rst_n = 1'b1;

    // Defaults, no backpressure.
    run_word(0, 32'hDEADBEEF, 1'b0, 0, 0);
    // Lower case with prefix on an 8-bit word.
    run_word(1, 32'h0000000A, 1'b0, 0, 0);
    // Random backpressure.
    run_word(0, 32'hDEADBEEF, 1'b1, 0, 0);
    // A second word offered mid-stream is ignored, then accepted later.
    run_word(0, 32'hDEADBEEF, 1'b0, 3, 0);
    run_word(0, 32'h12345678, 1'b0, 0, 0);
    // Reset after the third character.
    run_word(0, $urandom, 1'b0, 0, 3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle(0, "midrst");
    check_val("midrst_char", 32'(out_char[0]), 32'h0);
    run_word(0, 32'h00000001, 1'b0, 0, 0);
    // Single-digit instance without newline.
    run_word(2, 32'h0000000F, 1'b0, 0, 0);
    // Random words on random instances.
    for (int t = 0; t < 12; t++) begin
      run_word(int'($urandom_range(0, 2)), $urandom, 1'($urandom_range(0, 1)), 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
